// File: rtl/ttc_prescale_ctrl_lite_pkg.sv
// ============================================================================
// ttc_prescale_ctrl_lite_pkg : shared types and constants for the TTC prescaler
// Rev 1.0
// ============================================================================
`default_nettype none

package ttc_prescale_ctrl_lite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_RUN  = 2'b10
  } ctrl_state_e;

  localparam int c_cfg_w        = 7;
  localparam int c_cfg_ps_en    = 0;
  localparam int c_cfg_exp_lsb  = 1;
  localparam int c_cfg_exp_msb  = 4;
  localparam int c_cfg_ext_sel  = 5;
  localparam int c_cfg_ext_edge = 6;

  localparam int c_ps_w         = 16;
  localparam int c_sync_depth   = 2;

  localparam logic [c_ps_w-1:0] c_ps_ones = '1;

  // Terminal count for a divide-by-2^(N+1); N=15 shifts all ones out, giving 16'hFFFF.
  function automatic logic [c_ps_w-1:0] ps_terminal(input logic [3:0] exp_n);
    return ~(c_ps_ones << ({1'b0, exp_n} + 5'd1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ttc_prescale_ctrl_lite_if.sv
// ============================================================================
// ttc_prescale_ctrl_lite_if : control/status bundle between timer core and prescaler
// Rev 1.0
// ============================================================================
`default_nettype none

interface ttc_prescale_ctrl_lite_if;
  import ttc_prescale_ctrl_lite_pkg::*;

  logic [c_cfg_w-1:0] clk_ctrl_reg;
  logic               count_en;
  logic               restart;
  logic               ext_clk;
  logic               count_tick;
  logic [c_ps_w-1:0]  ps_count;
  logic [1:0]         ctrl_state;

  modport master (
    output clk_ctrl_reg, count_en, restart, ext_clk,
    input  count_tick, ps_count, ctrl_state
  );

  modport slave (
    input  clk_ctrl_reg, count_en, restart, ext_clk,
    output count_tick, ps_count, ctrl_state
  );

endinterface

`default_nettype wire

// File: rtl/ttc_ext_edge_det_lite.sv
// ============================================================================
// ttc_ext_edge_det_lite : ext_clk synchroniser with polarity-selected edge strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module ttc_ext_edge_det_lite
  import ttc_prescale_ctrl_lite_pkg::*;
#(
  parameter int SYNC_DEPTH = c_sync_depth
) (
  input  logic pclk,
  input  logic p_reset,
  input  logic i_ext_clk,
  input  logic i_edge_sel,
  output logic o_ext_event
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  event_q, event_d;
  logic                  w_sync_out;

  assign w_sync_out = sync_q[SYNC_DEPTH-1];

  // Edge select 1 picks falling edges, 0 picks rising edges.
  always_comb begin
    sync_d  = {sync_q[SYNC_DEPTH-2:0], i_ext_clk};
    prev_d  = w_sync_out;
    event_d = i_edge_sel ? (~w_sync_out & prev_q) : (w_sync_out & ~prev_q);
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      event_q <= event_d;
    end
  end

  assign o_ext_event = event_q;

endmodule

`default_nettype wire

// File: rtl/ttc_prescale_ctrl_lite.sv
// ============================================================================
// ttc_prescale_ctrl_lite : timer clock-source select, prescaler and run-control FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module ttc_prescale_ctrl_lite
  import ttc_prescale_ctrl_lite_pkg::*;
(
  input  logic                   pclk,
  input  logic                   p_reset,
  ttc_prescale_ctrl_lite_if.slave bus
);

  ctrl_state_e        state_q, state_d;
  logic [c_cfg_w-1:0] cfg_q, cfg_d;
  logic               restart_q, restart_d;
  logic [c_ps_w-1:0]  ps_count_q, ps_count_d;
  logic               count_tick_q, count_tick_d;

  logic               w_ext_event;
  logic               w_src_event;
  logic               w_cfg_change;
  logic               w_restart_edge;
  logic               w_terminal;

  ttc_ext_edge_det_lite #(
    .SYNC_DEPTH (c_sync_depth)
  ) u_ext_edge (
    .pclk        (pclk),
    .p_reset     (p_reset),
    .i_ext_clk   (bus.ext_clk),
    .i_edge_sel  (bus.clk_ctrl_reg[c_cfg_ext_edge]),
    .o_ext_event (w_ext_event)
  );

  assign w_src_event    = bus.clk_ctrl_reg[c_cfg_ext_sel] ? w_ext_event : 1'b1;
  assign w_cfg_change   = (bus.clk_ctrl_reg != cfg_q);
  assign w_restart_edge = bus.restart & ~restart_q;
  assign w_terminal     = (ps_count_q == ps_terminal(cfg_q[c_cfg_exp_msb:c_cfg_exp_lsb]));

  always_comb begin
    state_d      = state_q;
    ps_count_d   = ps_count_q;
    count_tick_d = 1'b0;
    cfg_d        = bus.clk_ctrl_reg;
    restart_d    = bus.restart;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_ARM;
        ps_count_d = '0;
      end
      ST_ARM: begin
        ps_count_d = '0;
        if (bus.count_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Restart beats a coincident terminal count; a config change costs one cycle.
        if (w_restart_edge) begin
          state_d    = ST_ARM;
          ps_count_d = '0;
        end else if (w_cfg_change) begin
          ps_count_d = '0;
        end else if (bus.count_en && w_src_event) begin
          if (!cfg_q[c_cfg_ps_en]) begin
            ps_count_d   = '0;
            count_tick_d = 1'b1;
          end else if (w_terminal) begin
            ps_count_d   = '0;
            count_tick_d = 1'b1;
          end else begin
            ps_count_d   = ps_count_q + c_ps_w'(1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ps_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      restart_q    <= 1'b0;
      ps_count_q   <= '0;
      count_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      restart_q    <= restart_d;
      ps_count_q   <= ps_count_d;
      count_tick_q <= count_tick_d;
    end
  end

  assign bus.count_tick = count_tick_q;
  assign bus.ps_count   = ps_count_q;
  assign bus.ctrl_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ttc_prescale_ctrl_lite.sv
// ============================================================================
// tb_ttc_prescale_ctrl_lite : directed + random bench with a behavioural reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ttc_prescale_ctrl_lite;

  logic pclk = 1'b0;
  logic p_reset;
  int   checks = 0;
  int   errors = 0;

  // Reference model: state as 0/1/2, prescale count as a plain integer.
  int         m_state;
  int         m_ps;
  int         m_tick;
  logic [6:0] m_cfg;
  logic       m_restart;
  logic       m_sel_prev;
  logic [3:0] m_hist;

  ttc_prescale_ctrl_lite_if bus();

  ttc_prescale_ctrl_lite dut (
    .pclk    (pclk),
    .p_reset (p_reset),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_ps       = 0;
    m_tick     = 0;
    m_cfg      = 7'h00;
    m_restart  = 1'b0;
    m_sel_prev = 1'b0;
    m_hist     = 4'h0;
  endtask

  // An ext edge counts 3 pclk edges after it was first sampled.
  task automatic model_step();
    logic cfg_chg;
    logic rs_edge;
    logic ext_ev;
    logic src;
    int   n;
    cfg_chg = (bus.clk_ctrl_reg != m_cfg);
    rs_edge = bus.restart && !m_restart;
    ext_ev  = m_sel_prev ? (!m_hist[2] && m_hist[3]) : (m_hist[2] && !m_hist[3]);
    src     = bus.clk_ctrl_reg[5] ? ext_ev : 1'b1;
    n       = int'(bus.clk_ctrl_reg[4:1]);
    m_tick  = 0;
    if (m_state == 0) begin
      m_state = 1;
      m_ps    = 0;
    end else if (m_state == 1) begin
      m_ps = 0;
      if (bus.count_en) m_state = 2;
    end else begin
      if (rs_edge) begin
        m_state = 1;
        m_ps    = 0;
      end else if (cfg_chg) begin
        m_ps = 0;
      end else if (bus.count_en && src) begin
        if (!bus.clk_ctrl_reg[0]) begin
          m_tick = 1;
        end else begin
          m_ps = m_ps + 1;
          if (m_ps == (1 << (n + 1))) begin
            m_ps   = 0;
            m_tick = 1;
          end
        end
      end
    end
    m_cfg      = bus.clk_ctrl_reg;
    m_restart  = bus.restart;
    m_sel_prev = bus.clk_ctrl_reg[6];
    m_hist     = {m_hist[2:0], bus.ext_clk};
  endtask

  task automatic cycle();
    if (p_reset) model_reset();
    else         model_step();
    @(posedge pclk);
    #1;
    chk("state", bus.ctrl_state, m_state);
    chk("ps_count", bus.ps_count, m_ps);
    chk("count_tick", bus.count_tick, m_tick);
  endtask

  task automatic wait_ps(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (int'(bus.ps_count) != target && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, (k < budget), 1);
  endtask

  task automatic cycles_to_tick(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (bus.count_tick !== 1'b1 && n < budget);
  endtask

  initial begin
    int n;
    int ticks;

    p_reset          = 1'b1;
    bus.clk_ctrl_reg = 7'h00;
    bus.count_en     = 1'b1;
    bus.restart      = 1'b0;
    bus.ext_clk      = 1'b0;
    model_reset();
    cycle();
    cycle();
    chk("rst_state", bus.ctrl_state, 0);
    chk("rst_ps", bus.ps_count, 0);
    chk("rst_tick", bus.count_tick, 0);

    // Internal source, prescaler off: tick every cycle from the 3rd cycle.
    p_reset = 1'b0;
    cycle();
    chk("arm_after_release", bus.ctrl_state, 1);
    cycle();
    chk("run_after_arm", bus.ctrl_state, 2);
    chk("no_tick_before_run", bus.count_tick, 0);
    cycle();
    chk("first_tick_3rd_cycle", bus.count_tick, 1);
    repeat (4) cycle();

    // Divide by 8.
    bus.clk_ctrl_reg = 7'h05;
    cycle();
    chk("cfg_chg_ps", bus.ps_count, 0);
    chk("cfg_chg_tick", bus.count_tick, 0);
    ticks = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (bus.count_tick) ticks++;
    end
    chk("div8_ticks", ticks, 3);

    // Restart edge at ps_count=5, restart held high afterwards.
    wait_ps(5, 20, "reach_ps5");
    bus.restart = 1'b1;
    cycle();
    chk("restart_state", bus.ctrl_state, 1);
    chk("restart_ps", bus.ps_count, 0);
    chk("restart_tick", bus.count_tick, 0);
    cycle();
    chk("restart_run", bus.ctrl_state, 2);
    cycles_to_tick(20, n);
    chk("restart_next_tick", n, 8);
    bus.restart = 1'b0;

    // Reconfigure to divide by 16 mid-count.
    wait_ps(6, 20, "reach_ps6");
    bus.clk_ctrl_reg = 7'h07;
    cycle();
    chk("reconf_ps", bus.ps_count, 0);
    chk("reconf_tick", bus.count_tick, 0);
    cycles_to_tick(40, n);
    chk("div16_first", n, 16);
    cycles_to_tick(40, n);
    chk("div16_second", n, 16);

    // External rising edges, divide by 2, ext period 10 pclk.
    bus.clk_ctrl_reg = 7'h21;
    cycle();
    ticks = 0;
    for (int j = 0; j < 40; j++) begin
      bus.ext_clk = ((j % 10) < 5);
      cycle();
      if (bus.count_tick) ticks++;
      if (j == 12) chk("ext_no_tick_early", bus.count_tick, 0);
      if (j == 13) chk("ext_tick_4_after_2nd", bus.count_tick, 1);
    end
    chk("ext_div2_ticks", ticks, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.clk_ctrl_reg = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            4'($urandom_range(0, 4)), 1'($urandom_range(0, 1))};
      end
      bus.count_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 29) == 0) bus.restart = ~bus.restart;
      if ($urandom_range(0, 2) == 0)  bus.ext_clk = ~bus.ext_clk;
      cycle();
    end

    // Asynchronous reset mid-count.
    bus.clk_ctrl_reg = 7'h05;
    bus.restart      = 1'b0;
    bus.count_en     = 1'b1;
    bus.ext_clk      = 1'b0;
    repeat (3) cycle();
    wait_ps(3, 40, "reach_ps3");
    #2;
    p_reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_state", bus.ctrl_state, 0);
    chk("async_rst_ps", bus.ps_count, 0);
    chk("async_rst_tick", bus.count_tick, 0);
    cycle();
    cycle();
    p_reset = 1'b0;
    cycle();
    chk("rearm_state", bus.ctrl_state, 1);
    chk("rearm_tick", bus.count_tick, 0);
    cycle();
    chk("rerun_ps", bus.ps_count, 0);
    cycle();
    chk("recount_ps", bus.ps_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
